// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS definitions used by the transmit and receive paths.
//   TMDS_W            width of one TMDS symbol
//   COLOR_W           width of one decoded colour byte
//   CTRL_TOKEN_xx     the four control tokens, suffix is {C1,C0}
//   rx_align_state_t  receive word-alignment FSM states
//   tmds_dec_t        decoded symbol: de, ctrl {C1,C0}, data byte
//   is_ctrl_token()   1 when a word is one of the four control tokens
package dvi_pkg;

    localparam int TMDS_W  = 10;
    localparam int COLOR_W = 8;

    localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        RX_SEARCH = 2'd0,
        RX_SLIP   = 2'd1,
        RX_WAIT   = 2'd2,
        RX_LOCKED = 2'd3
    } rx_align_state_t;

    typedef struct packed {
        logic               de;
        logic [1:0]         ctrl;
        logic [COLOR_W-1:0] data;
    } tmds_dec_t;

    function automatic logic is_ctrl_token(input logic [TMDS_W-1:0] word);
        return (word == CTRL_TOKEN_00) || (word == CTRL_TOKEN_01) ||
               (word == CTRL_TOKEN_10) || (word == CTRL_TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_channel_rx_if.sv
// Symbol/decoded-output bundle of one TMDS receive channel.
//   sym_i      raw 10-bit deserialized word, bit 0 first on the wire
//   bitslip_o  one-cycle request for a one-bit rotation in the deserializer
//   locked_o   word alignment established
//   de_o       1 = video data symbol
//   ctrl_o     {C1,C0} from a control token
//   data_o     decoded data byte
//   state_dbg  alignment FSM state, for observation only
// There is no valid/ready pair: the channel is a free-running stream, one
// symbol in and one decoded result out on every clock, with no back-pressure.
// master = deserializer/consumer side, slave = the receiver.
interface tmds_channel_rx_if;
    import dvi_pkg::*;

    logic [TMDS_W-1:0]  sym_i;
    logic               bitslip_o;
    logic               locked_o;
    logic               de_o;
    logic [1:0]         ctrl_o;
    logic [COLOR_W-1:0] data_o;
    rx_align_state_t    state_dbg;

    modport master (
        output sym_i,
        input  bitslip_o, locked_o, de_o, ctrl_o, data_o, state_dbg
    );

    modport slave (
        input  sym_i,
        output bitslip_o, locked_o, de_o, ctrl_o, data_o, state_dbg
    );

endinterface

// File: rtl/tmds_decode_word.sv
// Combinational TMDS word decoder (DVI only, no TERC4).
//   word  10-bit aligned TMDS symbol
//   dec   {de, ctrl, data}: control token -> de=0, ctrl, data=0;
//         any other word -> de=1, ctrl=0, data decoded (invalid words
//         simply decode as data).
module tmds_decode_word
    import dvi_pkg::*;
(
    input  logic [TMDS_W-1:0] word,
    output tmds_dec_t         dec
);

    logic [COLOR_W-1:0] q_m;

    always_comb begin
        dec = '0;
        q_m = '0;
        case (word)
            CTRL_TOKEN_00: dec.ctrl = 2'b00;
            CTRL_TOKEN_01: dec.ctrl = 2'b01;
            CTRL_TOKEN_10: dec.ctrl = 2'b10;
            CTRL_TOKEN_11: dec.ctrl = 2'b11;
            default: begin
                dec.de = 1'b1;
                // bit 9 marks a DC-balancing inversion of the payload
                q_m = word[9] ? ~word[7:0] : word[7:0];
                dec.data[0] = q_m[0];
                // bit 8 selects XOR (1) or XNOR (0) transition coding
                for (int k = 1; k < COLOR_W; k++) begin
                    dec.data[k] = word[8] ? (q_m[k] ^ q_m[k-1])
                                          : ~(q_m[k] ^ q_m[k-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel: word alignment by bitslip plus decode.
//   clk_i    pixel clock (single domain)
//   rst_n_i  synchronous active-low reset
//   rx       tmds_channel_rx_if.slave: sym_i in; bitslip_o, locked_o,
//            de_o, ctrl_o, data_o, state_dbg out
// Alignment: a run of CTRL_RUN consecutive control tokens locks the channel.
// Without such a run inside SEARCH_TIMEOUT symbols, SEARCH requests a bitslip
// and waits SLIP_WAIT cycles; LOCKED falls back to SEARCH without slipping.
// Decode path: sym_i -> sym_d1 -> dec_q -> out_q, i.e. a symbol sampled at
// edge N appears on the outputs after edge N+2, gated by the current lock.
module tmds_channel_rx
    import dvi_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_WAIT      = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    tmds_channel_rx_if.slave rx
);

    localparam int RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int WIN_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(CTRL_RUN);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    rx_align_state_t   state_q;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_nxt;
    logic [WIN_W-1:0]  win_q;
    logic [WAIT_W-1:0] wait_q;
    logic              bitslip_q;
    logic [TMDS_W-1:0] sym_d1;
    tmds_dec_t         dec_w;
    tmds_dec_t         dec_q;
    tmds_dec_t         out_q;
    logic              tok_in;
    logic              run_full;
    logic              win_end;
    logic              locked;

    assign tok_in   = is_ctrl_token(rx.sym_i);
    assign run_full = (run_q == RUN_FULL);
    assign win_end  = (win_q == WIN_LAST);

    // run of consecutive tokens, saturating so it can never wrap
    always_comb begin
        run_nxt = '0;
        if (tok_in) begin
            run_nxt = run_full ? run_q : run_q + RUN_W'(1);
        end
    end

    tmds_decode_word u_decode (
        .word (sym_d1),
        .dec  (dec_w)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= RX_SEARCH;
            run_q     <= '0;
            win_q     <= '0;
            wait_q    <= '0;
            bitslip_q <= 1'b0;
            sym_d1    <= '0;
            dec_q     <= '0;
            out_q     <= '0;
        end else begin
            sym_d1    <= rx.sym_i;
            dec_q     <= dec_w;
            out_q     <= dec_q;
            bitslip_q <= 1'b0;
            case (state_q)
                RX_SEARCH: begin
                    run_q <= run_nxt;
                    // a completed run beats a timeout on the same edge
                    if (run_full) begin
                        state_q <= RX_LOCKED;
                        win_q   <= '0;
                    end else if (win_end) begin
                        state_q   <= RX_SLIP;
                        bitslip_q <= 1'b1;
                        run_q     <= '0;
                        win_q     <= '0;
                    end else begin
                        win_q <= win_q + WIN_W'(1);
                    end
                end
                RX_SLIP: begin
                    state_q <= RX_WAIT;
                    run_q   <= '0;
                    win_q   <= '0;
                    wait_q  <= '0;
                end
                RX_WAIT: begin
                    // deserializer output is unsettled; ignore it entirely
                    run_q <= '0;
                    win_q <= '0;
                    if (wait_q == WAIT_LAST) begin
                        state_q <= RX_SEARCH;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                RX_LOCKED: begin
                    run_q <= run_nxt;
                    if (run_full) begin
                        win_q <= '0;
                    end else if (win_end) begin
                        // alignment lost: search again from the current phase
                        state_q <= RX_SEARCH;
                        run_q   <= '0;
                        win_q   <= '0;
                    end else begin
                        win_q <= win_q + WIN_W'(1);
                    end
                end
                default: begin
                    state_q <= RX_SEARCH;
                    run_q   <= '0;
                    win_q   <= '0;
                    wait_q  <= '0;
                end
            endcase
        end
    end

    assign locked       = (state_q == RX_LOCKED);
    assign rx.locked_o  = locked;
    assign rx.bitslip_o = bitslip_q;
    assign rx.de_o      = locked & out_q.de;
    assign rx.ctrl_o    = locked ? out_q.ctrl : 2'b00;
    assign rx.data_o    = locked ? out_q.data : '0;
    assign rx.state_dbg = state_q;

endmodule
